// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, flag bit positions and FSM states.
package alu_arbiter_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SLR = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;
    localparam logic [3:0] OP_NON = 4'd15;

    localparam int FLG_S = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: request and response handshakes for NREQ requesters.
// req_lock exists only when ALU_ARB_LOCK_EN is defined.
interface alu_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DATA_W-1:0] req_a;
    logic [NREQ*DATA_W-1:0] req_b;
    logic [NREQ*OP_W-1:0]   req_op;
`ifdef ALU_ARB_LOCK_EN
    logic [NREQ-1:0]        req_lock;
`endif
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]      rsp_data;
    logic [3:0]             rsp_flag;

    modport master (
`ifdef ALU_ARB_LOCK_EN
        output req_lock,
`endif
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_flag
    );

    modport slave (
`ifdef ALU_ARB_LOCK_EN
        input  req_lock,
`endif
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_flag
    );

endinterface

// File: rtl/alu_rr_pick.sv
// Combinational round-robin pick: first valid index after 'last', wrapping modulo NREQ.
module alu_rr_pick
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int unsigned cand;

    // Scan from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = 0;
        any   = |valid;
        for (int unsigned off = NREQ; off >= 1; off--) begin
            cand = (32'(last) + off) % NREQ;
            if (valid[cand[IDX_W-1:0]]) begin
                grant                   = '0;
                grant[cand[IDX_W-1:0]]  = 1'b1;
                idx                     = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters: round-robin admit, registered operands/result.
// Optional grant locking is enabled with the ALU_ARB_LOCK_EN macro.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_s,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [3:0]        alu_flag
);

    localparam int IDX_W = idx_width(NREQ);

    arb_state_t        state;
    logic [IDX_W-1:0]  last;
    logic [NREQ-1:0]   pick_grant;
    logic [NREQ-1:0]   last_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic              pick_any;
    logic              lock_go;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [OP_W-1:0]   sel_op;

    alu_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid (bus.req_valid),
        .last  (last),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // 'last' doubles as the current grant index once an op has been admitted.
    always_comb begin
        last_oh       = '0;
        last_oh[last] = 1'b1;
    end

    always_comb begin
        lock_go = 1'b0;
`ifdef ALU_ARB_LOCK_EN
        lock_go = (state == ST_RESP) && bus.rsp_ready[last]
                  && bus.req_lock[last] && bus.req_valid[last];
`endif
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == ST_IDLE && pick_any) begin
            bus.req_ready = pick_grant;
        end else if (lock_go) begin
            bus.req_ready = last_oh;
        end
    end

    always_comb begin
        sel_idx = (state == ST_IDLE) ? pick_idx : last;
        sel_a   = '0;
        sel_b   = '0;
        sel_op  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_a  = bus.req_a[i*DATA_W +: DATA_W];
                sel_b  = bus.req_b[i*DATA_W +: DATA_W];
                sel_op = bus.req_op[i*OP_W +: OP_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            last          <= IDX_W'(NREQ - 1);
            alu_a         <= '0;
            alu_b         <= '0;
            alu_s         <= OP_NON;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_flag  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        alu_a <= sel_a;
                        alu_b <= sel_b;
                        alu_s <= sel_op;
                        last  <= pick_idx;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // NON leaves the ALU flags stale, so the response is forced to zero.
                    if (alu_s == OP_NON) begin
                        bus.rsp_data <= '0;
                        bus.rsp_flag <= '0;
                    end else begin
                        bus.rsp_data <= alu_res;
                        bus.rsp_flag <= alu_flag;
                    end
                    alu_s         <= OP_NON;
                    bus.rsp_valid <= last_oh;
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready[last]) begin
                        bus.rsp_valid <= '0;
                        if (lock_go) begin
                            alu_a <= sel_a;
                            alu_b <= sel_b;
                            alu_s <= sel_op;
                            state <= ST_EXEC;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    alu_s         <= OP_NON;
                    bus.rsp_valid <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU and a round-robin reference model.
// Lock tests run when ALU_ARB_LOCK_EN is defined.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NREQ = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_s, alu_flag;

    always #5 clk = ~clk;

    alu_arbiter_if #(.NREQ(NREQ)) bus ();

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_s    (alu_s),
        .alu_res  (alu_res),
        .alu_flag (alu_flag)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        int unsigned idx;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic [15:0] data;
        logic [3:0]  flag;
        int          acc_cyc;
    } exp_t;

    exp_t            sbq[$];
    int unsigned     m_last = NREQ - 1;
    logic [NREQ-1:0] acc_mask = '0;

    // Behavioural 16-bit ALU: {S,Z,C,V, result}; C on SUB is borrow.
    function automatic logic [19:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        c, v;
        logic [3:0]  sh;
        sh = b[3:0]; s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; v = (a[15] == b[15]) && (r[15] != a[15]); end
            OP_SUB: begin r = a - b; c = (a < b); v = (a[15] != b[15]) && (r[15] != a[15]); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SLL: r = a << sh;
            OP_SLR: r = (a << sh) | (a >> (5'd16 - {1'b0, sh}));
            OP_SRL: r = a >> sh;
            OP_SRA: r = $signed(a) >>> sh;
            OP_NON: return {4'b1010, 16'hDEAD};
            default: r = ~a;
        endcase
        return {r[15], (r == 16'h0000), c, v, r};
    endfunction

    always_comb {alu_flag, alu_res} = alu_f(alu_s, alu_a, alu_b);

    function automatic int unsigned rr_model(input logic [NREQ-1:0] v, input int unsigned last);
        for (int unsigned k = 1; k <= NREQ; k++)
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return last;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: required event not seen within bound (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: response checks and pops first, then admission checks and pushes.
    always @(negedge clk) begin : mon
        logic            popped;
        int unsigned     pidx;
        int unsigned     w;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] oh;
        exp_t            e;
        popped = 1'b0; pidx = 0; w = 0; exp_rdy = '0; oh = '0;
        acc_mask = '0;
        if (!rst_n) begin
            sbq.delete();
            m_last = NREQ - 1;
        end else begin
            if (sbq.size() == 0) begin
                check("rsp_idle", 32'(bus.rsp_valid), 32'h0);
                check("alu_s_idle", 32'(alu_s), 32'hF);
            end else if (cyc < sbq[0].acc_cyc + 2) begin
                check("rsp_early", 32'(bus.rsp_valid), 32'h0);
                if (cyc == sbq[0].acc_cyc + 1) begin
                    check("alu_a_in", 32'(alu_a), 32'(sbq[0].a));
                    check("alu_b_in", 32'(alu_b), 32'(sbq[0].b));
                    check("alu_s_in", 32'(alu_s), 32'(sbq[0].op));
                end
            end else begin
                oh = '0;
                oh[sbq[0].idx] = 1'b1;
                check("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
                check("rsp_data", 32'(bus.rsp_data), 32'(sbq[0].data));
                check("rsp_flag", 32'(bus.rsp_flag), 32'(sbq[0].flag));
                check("alu_s_resp", 32'(alu_s), 32'hF);
                if (bus.rsp_ready[sbq[0].idx]) begin
                    pidx = sbq[0].idx;
                    void'(sbq.pop_front());
                    popped = 1'b1;
                end
            end

            if (popped) begin
`ifdef ALU_ARB_LOCK_EN
                if (bus.req_lock[pidx] && bus.req_valid[pidx]) begin
                    w = pidx;
                    exp_rdy[w] = 1'b1;
                end
`endif
            end else if (sbq.size() == 0 && |bus.req_valid) begin
                w = rr_model(bus.req_valid, m_last);
                exp_rdy[w] = 1'b1;
            end
            check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            if (exp_rdy != '0) begin
                e.idx     = w;
                e.a       = bus.req_a[w*16 +: 16];
                e.b       = bus.req_b[w*16 +: 16];
                e.op      = bus.req_op[w*4 +: 4];
                e.acc_cyc = cyc;
                if (e.op == OP_NON) {e.flag, e.data} = 20'h0;
                else                {e.flag, e.data} = alu_f(e.op, e.a, e.b);
                sbq.push_back(e);
                m_last   = w;
                acc_mask = bus.req_valid & bus.req_ready;
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.req_valid[i]     = v;
        bus.req_op[i*4 +: 4] = op;
        bus.req_a[i*16 +: 16] = a;
        bus.req_b[i*16 +: 16] = b;
    endtask

    task automatic wait_accept(input int i, output int t);
        t = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.req_ready[i]) begin t = cyc; break; end
        end
        if (t < 0) note_timeout("accept_wait");
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(input int i, output int t);
        t = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.rsp_valid[i]) begin t = cyc; break; end
        end
        if (t < 0) note_timeout("rsp_wait");
    endtask

    task automatic wait_any(output logic [NREQ-1:0] g);
        g = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (|bus.req_ready) begin g = bus.req_ready; break; end
        end
        if (g == '0) note_timeout("grant_wait");
    endtask

    task automatic drain();
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.rsp_ready = '1;
`ifdef ALU_ARB_LOCK_EN
        bus.req_lock = '0;
`endif
        for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic rand_req(input int i);
        logic [3:0]  ops[12] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SLR,
                                 OP_SRL, OP_SRA, OP_NON, 4'h5, 4'hD};
        logic [15:0] corner[4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
        logic [15:0] a, b;
        a = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(3, 0)] : 16'($urandom);
        b = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(3, 0)] : 16'($urandom);
        set_req(i, ($urandom_range(3, 0) != 0), ops[$urandom_range(11, 0)], a, b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int              ta, tr, t1, t2, t3;
        int              n;
        bit              seen_sub;
        logic [NREQ-1:0] g;
        logic [1:0]      g_exp[4] = '{2'b10, 2'b01, 2'b10, 2'b01};

        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
        bus.rsp_ready = '0;
`ifdef ALU_ARB_LOCK_EN
        bus.req_lock = '0;
`endif
        @(posedge clk); #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
        check("rst_rsp_flag", 32'(bus.rsp_flag), 32'h0);
        check("rst_alu_ab", {alu_a, alu_b}, 32'h0);
        check("rst_alu_s", 32'(alu_s), 32'hF);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single ADD with signed overflow
        bus.rsp_ready = '1;
        set_req(0, 1'b1, OP_ADD, 16'h7FFF, 16'h0001);
        wait_accept(0, ta);
        bus.req_valid[0] = 1'b0;
        wait_rsp(0, tr);
        check("t1_latency", 32'(tr - ta), 32'd2);
        check("t1_data", 32'(bus.rsp_data), 32'h8000);
        check("t1_flag", 32'(bus.rsp_flag), 32'b1001);
        drain();

        // Both requesters continuously valid: grants alternate
        set_req(0, 1'b1, OP_ADD, 16'h1234, 16'h1111);
        set_req(1, 1'b1, OP_SUB, 16'h0005, 16'h0005);
        n = 0; seen_sub = 1'b0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (bus.rsp_valid[1] && !seen_sub) begin
                check("t2_sub_data", 32'(bus.rsp_data), 32'h0);
                check("t2_sub_flag", 32'(bus.rsp_flag), 32'b0100);
                seen_sub = 1'b1;
            end
            if (|bus.req_ready) begin
                check("t2_grant", 32'(bus.req_ready), 32'(g_exp[n]));
                n++;
            end
        end
        if (n < 4) note_timeout("t2_grants");
        drain();

        // Backpressure on an SRA response
        bus.rsp_ready = '0;
        set_req(0, 1'b1, OP_SRA, 16'h8000, 16'h0004);
        wait_accept(0, ta);
        bus.req_valid[0] = 1'b0;
        set_req(1, 1'b1, OP_XOR, 16'hAAAA, 16'h5555);
        wait_rsp(0, tr);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("t3_data", 32'(bus.rsp_data), 32'hF800);
            check("t3_req_ready", 32'(bus.req_ready), 32'h0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = '1;
        wait_accept(1, ta);
        bus.req_valid[1] = 1'b0;
        drain();

        // NON after an ADD that sets carry
        set_req(0, 1'b1, OP_ADD, 16'hFFFF, 16'h0001);
        wait_accept(0, ta);
        set_req(0, 1'b1, OP_NON, 16'h1234, 16'h5678);
        wait_rsp(0, tr);
        check("t4_add_flag", 32'(bus.rsp_flag), 32'b0110);
        wait_accept(0, ta);
        bus.req_valid[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t4_alu_s", 32'(alu_s), 32'hF);
        end
        check("t4_valid", 32'(bus.rsp_valid), 32'b01);
        check("t4_data", 32'(bus.rsp_data), 32'h0);
        check("t4_flag", 32'(bus.rsp_flag), 32'h0);
        drain();

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc_mask[i] || (!bus.req_valid[i] && $urandom_range(1, 0) == 1))
                    rand_req(i);
                else if (bus.req_valid[i] && $urandom_range(9, 0) == 0)
                    bus.req_valid[i] = 1'b0;
`ifdef ALU_ARB_LOCK_EN
                bus.req_lock[i] = ($urandom_range(2, 0) == 0);
`endif
            end
            bus.rsp_ready = NREQ'($urandom);
        end
        drain();

        // Reset during EXEC
        set_req(0, 1'b1, OP_OR, 16'h0F0F, 16'h3031);
        wait_accept(0, ta);
        bus.req_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("t5_req_ready", 32'(bus.req_ready), 32'h0);
        check("t5_rsp_data", 32'(bus.rsp_data), 32'h0);
        check("t5_rsp_flag", 32'(bus.rsp_flag), 32'h0);
        check("t5_alu_ab", {alu_a, alu_b}, 32'h0);
        check("t5_alu_s", 32'(alu_s), 32'hF);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(0, 1'b1, OP_ADD, 16'h0001, 16'h0002);
        set_req(1, 1'b1, OP_ADD, 16'h0003, 16'h0004);
        wait_any(g);
        check("t5_first_grant", 32'(g), 32'b01);
        drain();

`ifdef ALU_ARB_LOCK_EN
        // Locked requester 1 served three times back-to-back
        bus.req_lock[1] = 1'b1;
        set_req(1, 1'b1, OP_ADD, 16'h0001, 16'h0001);
        wait_accept(1, t1);
        set_req(0, 1'b1, OP_AND, 16'hFFFF, 16'h00FF);
        set_req(1, 1'b1, OP_ADD, 16'h0002, 16'h0002);
        wait_accept(1, t2);
        check("t6_gap1", 32'(t2 - t1), 32'd2);
        set_req(1, 1'b1, OP_ADD, 16'h0003, 16'h0003);
        wait_accept(1, t3);
        check("t6_gap2", 32'(t3 - t2), 32'd2);
        bus.req_lock[1] = 1'b0;
        set_req(1, 1'b1, OP_SUB, 16'h0009, 16'h0001);
        wait_any(g);
        check("t6_then_req0", 32'(g), 32'b01);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
